// File: rtl/key_search_arbiter.sv
// Collects success/failure/key outputs from replicated RC4 cracking cores,
// selects a single winner, broadcasts stop and reports result plus search time.
module key_search_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = 24,
    parameter int CNT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [NUM_CORES-1:0]           core_success,
    input  logic [NUM_CORES-1:0]           core_failure,
    input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic                           cores_reset_n,
    output logic                           stop,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [$clog2(NUM_CORES)-1:0]   winner_idx,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [CNT_WIDTH-1:0]           search_cycles
);

    localparam int IDX_W = $clog2(NUM_CORES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SEARCH = 3'd2,
        ST_FOUND  = 3'd3,
        ST_EXH    = 3'd4
    } state_t;

    state_t                         state_q;
    logic                           clr_cnt_q;
    logic [NUM_CORES-1:0]           s_q;
    logic [NUM_CORES-1:0]           f_q;
    logic [NUM_CORES*KEY_WIDTH-1:0] k_q;
    logic [NUM_CORES-1:0]           fail_seen_q;
    logic                           cores_reset_n_q;
    logic                           stop_q;
    logic                           found_q;
    logic                           exhausted_q;
    logic [IDX_W-1:0]               winner_idx_q;
    logic [KEY_WIDTH-1:0]           found_key_q;
    logic [CNT_WIDTH-1:0]           search_cycles_q;

    logic [IDX_W-1:0]               win_idx_d;
    logic [KEY_WIDTH-1:0]           win_key_d;
    logic [CNT_WIDTH-1:0]           search_cycles_d;
    logic                           any_succ_s;
    logic                           all_fail_s;

    // Lowest-index priority select over the registered copies keeps key and flag coherent
    always_comb begin
        win_idx_d = {IDX_W{1'b0}};
        win_key_d = {KEY_WIDTH{1'b0}};
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            win_idx_d = s_q[i] ? IDX_W'(i) : win_idx_d;
            win_key_d = s_q[i] ? k_q[i*KEY_WIDTH +: KEY_WIDTH] : win_key_d;
        end
        any_succ_s      = |s_q;
        all_fail_s      = &(fail_seen_q | f_q);
        search_cycles_d = (search_cycles_q == {CNT_WIDTH{1'b1}}) ? search_cycles_q
                        : search_cycles_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    // Single register stage on all core outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q <= {NUM_CORES{1'b0}};
            f_q <= {NUM_CORES{1'b0}};
            k_q <= {(NUM_CORES*KEY_WIDTH){1'b0}};
        end else begin
            s_q <= core_success;
            f_q <= core_failure;
            k_q <= core_key;
        end
    end

    // Search control FSM with registered result and core-control outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            clr_cnt_q       <= 1'b0;
            fail_seen_q     <= {NUM_CORES{1'b0}};
            cores_reset_n_q <= 1'b0;
            stop_q          <= 1'b0;
            found_q         <= 1'b0;
            exhausted_q     <= 1'b0;
            winner_idx_q    <= {IDX_W{1'b0}};
            found_key_q     <= {KEY_WIDTH{1'b0}};
            search_cycles_q <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_FOUND, ST_EXH: begin
                    if (start) begin
                        state_q         <= ST_CLEAR;
                        clr_cnt_q       <= 1'b0;
                        cores_reset_n_q <= 1'b0;
                        stop_q          <= 1'b0;
                        found_q         <= 1'b0;
                        exhausted_q     <= 1'b0;
                        winner_idx_q    <= {IDX_W{1'b0}};
                        found_key_q     <= {KEY_WIDTH{1'b0}};
                        search_cycles_q <= {CNT_WIDTH{1'b0}};
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_CLEAR: begin
                    fail_seen_q <= {NUM_CORES{1'b0}};
                    if (clr_cnt_q) begin
                        state_q         <= ST_SEARCH;
                        clr_cnt_q       <= 1'b0;
                        cores_reset_n_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    search_cycles_q <= search_cycles_d;
                    fail_seen_q     <= fail_seen_q | f_q;
                    // Success takes precedence over a simultaneous final failure
                    if (any_succ_s) begin
                        state_q      <= ST_FOUND;
                        found_q      <= 1'b1;
                        stop_q       <= 1'b1;
                        winner_idx_q <= win_idx_d;
                        found_key_q  <= win_key_d;
                    end else if (all_fail_s) begin
                        state_q     <= ST_EXH;
                        exhausted_q <= 1'b1;
                        stop_q      <= 1'b1;
                    end else begin
                        state_q <= ST_SEARCH;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    clr_cnt_q       <= 1'b0;
                    cores_reset_n_q <= 1'b0;
                    stop_q          <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = (state_q == ST_CLEAR) || (state_q == ST_SEARCH);
    assign cores_reset_n = cores_reset_n_q;
    assign stop          = stop_q;
    assign found         = found_q;
    assign exhausted     = exhausted_q;
    assign winner_idx    = winner_idx_q;
    assign found_key     = found_key_q;
    assign search_cycles = search_cycles_q;

endmodule

// File: tb/tb_key_search_arbiter.sv
// Directed bench for key_search_arbiter: expected results are queued when the
// deciding stimulus is driven and compared once the arbiter raises stop.
module tb_key_search_arbiter;

    localparam int N  = 4;
    localparam int KW = 24;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [N-1:0]    core_success = '0;
    logic [N-1:0]    core_failure = '0;
    logic [N*KW-1:0] core_key = '0;
    logic            cores_reset_n, stop, busy, found, exhausted;
    logic [1:0]      winner_idx;
    logic [KW-1:0]   found_key;
    logic [CW-1:0]   search_cycles;

    key_search_arbiter #(.NUM_CORES(N), .KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .core_success(core_success), .core_failure(core_failure), .core_key(core_key),
        .cores_reset_n(cores_reset_n), .stop(stop), .busy(busy), .found(found),
        .exhausted(exhausted), .winner_idx(winner_idx), .found_key(found_key),
        .search_cycles(search_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          f;
        logic          e;
        logic [1:0]    idx;
        logic [KW-1:0] key;
        logic [CW-1:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pulse_fail(input int idx);
        core_failure[idx] = 1'b1;
        adv(1);
        core_failure = '0;
    endtask

    // Deciding input driven at negedge k: captured at S+k+1, FSM leaves at S+k+2
    task automatic push_exp(input logic f, input logic e, input logic [1:0] idx, input logic [KW-1:0] key);
        exp_t x;
        x.f = f; x.e = e; x.idx = idx; x.key = key; x.cyc = CW'(k + 2);
        sb.push_back(x);
    endtask

    task automatic start_search();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_T", busy, 1);
        check("stop_dropped", stop, 0);
        check("found_cleared", found, 0);
        check("exh_cleared", exhausted, 0);
        check("key_cleared", found_key, 0);
        check("cycles_cleared", search_cycles, 0);
        check("crst_after_T", cores_reset_n, 0);
        @(negedge clk);
        check("crst_after_T1", cores_reset_n, 0);
        @(negedge clk);
        check("crst_after_T2", cores_reset_n, 1);
        check("busy_search", busy, 1);
        k = 0;
    endtask

    task automatic finish_check();
        exp_t x;
        int   w;
        w = 0;
        while (w < 10) begin
            @(negedge clk);
            w++;
            core_success = '0;
            core_failure = '0;
            if (stop) break;
        end
        x = sb.pop_front();
        check("stop_latency", 64'(w), 2);
        check("found", found, x.f);
        check("exhausted", exhausted, x.e);
        check("winner_idx", winner_idx, x.idx);
        check("found_key", found_key, x.key);
        check("search_cycles", search_cycles, x.cyc);
        check("busy_done", busy, 0);
        check("crst_done", cores_reset_n, 1);
        adv(2);
        check("frozen_cycles", search_cycles, x.cyc);
        check("frozen_stop", stop, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs
        repeat (5) begin
            core_success = N'($urandom);
            core_failure = N'($urandom);
            core_key     = {$urandom, $urandom, $urandom};
            start        = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("rst_crst", cores_reset_n, 0);
        check("rst_stop", stop, 0);
        check("rst_busy", busy, 0);
        check("rst_found", found, 0);
        check("rst_exh", exhausted, 0);
        check("rst_idx", winner_idx, 0);
        check("rst_key", found_key, 0);
        check("rst_cycles", search_cycles, 0);
        core_success = '0; core_failure = '0; core_key = '0; start = 1'b0;
        reset_n = 1'b1;
        adv(2);
        check("idle_after_rst", busy, 0);

        // Single winner on core 2
        start_search();
        adv(9);
        core_success[2] = 1'b1;
        core_key[2*KW +: KW] = 24'h0001A3;
        push_exp(1'b1, 1'b0, 2'd2, 24'h0001A3);
        finish_check();

        // Priority: cores 1 and 3 together
        start_search();
        adv(3);
        core_key[0*KW +: KW] = 24'hAAAAAA;
        core_key[1*KW +: KW] = 24'h000011;
        core_key[2*KW +: KW] = 24'h222222;
        core_key[3*KW +: KW] = 24'h000033;
        core_success = 4'b1010;
        push_exp(1'b1, 1'b0, 2'd1, 24'h000011);
        finish_check();

        // Exhaustion from one-cycle failure pulses
        start_search();
        adv(4);  pulse_fail(0);
        adv(3);  pulse_fail(1);
        adv(4);  pulse_fail(2);
        check("no_early_exh", exhausted, 0);
        check("no_early_stop", stop, 0);
        adv(5);
        core_failure[3] = 1'b1;
        push_exp(1'b0, 1'b1, 2'd0, 24'h000000);
        finish_check();

        // Tie: final failure on core 3 with success on core 0
        start_search();
        adv(2);  pulse_fail(0);
        adv(2);  pulse_fail(1);
        adv(2);  pulse_fail(2);
        adv(1);
        core_failure[3] = 1'b1;
        core_success[0] = 1'b1;
        core_key[0*KW +: KW] = 24'hABCDEF;
        push_exp(1'b1, 1'b0, 2'd0, 24'hABCDEF);
        finish_check();

        // Restart from FOUND, start ignored during SEARCH
        start_search();
        adv(3);
        check("count_3", search_cycles, 3);
        start = 1'b1;
        adv(1);
        start = 1'b0;
        adv(2);
        check("count_6", search_cycles, 6);
        check("busy_kept", busy, 1);
        check("crst_kept", cores_reset_n, 1);
        adv(1);
        core_success[3] = 1'b1;
        core_key[3*KW +: KW] = 24'h5A5A5A;
        push_exp(1'b1, 1'b0, 2'd3, 24'h5A5A5A);
        finish_check();

        // Async reset mid-search
        start_search();
        adv(5);
        reset_n = 1'b0;
        #1;
        check("abort_crst", cores_reset_n, 0);
        check("abort_busy", busy, 0);
        check("abort_stop", stop, 0);
        check("abort_cycles", search_cycles, 0);
        check("abort_found", found, 0);
        @(negedge clk);
        reset_n = 1'b1;
        adv(3);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_crst", cores_reset_n, 0);
        check("abort_idle_cycles", search_cycles, 0);

        // Immediate success after relaunch
        start_search();
        core_success[1] = 1'b1;
        core_key[1*KW +: KW] = 24'h000077;
        push_exp(1'b1, 1'b0, 2'd1, 24'h000077);
        finish_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_search_arbiter.md
# key_search_arbiter

Downstream collector for the replicated RC4 cracking cores. It gathers each core's `success`, `total_failure` and `secret_key` outputs and picks a single winner. It broadcasts `stop` to every core once the search is resolved, either by a key being found or by all cores exhausting their key ranges. It also controls the cores' shared reset and reports the result and elapsed search cycles to the top level for display.

## Interface
- `NUM_CORES`, default 4: number of cores arbitrated; must be 2 or more.
- `KEY_WIDTH`, default 24: width of each core's secret key.
- `CNT_WIDTH`, default 32: width of the search-cycle counter.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that launches or relaunches a search.
- `core_success`  in  NUM_CORES  bit i is core i's `success`.
- `core_failure`  in  NUM_CORES  bit i is core i's `total_failure`; may be a pulse or a level.
- `core_key`  in  NUM_CORES*KEY_WIDTH  core i's key at `[i*KEY_WIDTH +: KEY_WIDTH]`.
- `cores_reset_n`  out  1  active-low reset driven to every core.
- `stop`  out  1  broadcast stop to every core.
- `busy`  out  1  high in CLEAR or SEARCH.
- `found`  out  1  a key was found.
- `exhausted`  out  1  all cores failed; no key found.
- `winner_idx`  out  $clog2(NUM_CORES)  index of the winning core.
- `found_key`  out  KEY_WIDTH  the winning key.
- `search_cycles`  out  CNT_WIDTH  number of cycles spent in SEARCH.

## Operation
- States: IDLE, CLEAR, SEARCH, FOUND, EXHAUSTED.
- Reset (async on `reset_n`=0, including mid-search):
  - State goes to IDLE.
  - All outputs go to 0, so `cores_reset_n`=0 and `stop`=0.
  - Input registers and the sticky failure bits are cleared.
- Input stage: `core_success`, `core_failure` and `core_key` are registered once (`s_r`, `f_r`, `k_r`). The FSM uses only the registered copies.
- Sticky failure: `fail_seen[i]` is set when `f_r[i]`=1 in SEARCH, and is cleared in CLEAR.
- IDLE:
  - `cores_reset_n`=0.
  - `start`=1 moves to CLEAR.
- CLEAR (exactly 2 cycles):
  - `cores_reset_n`=0.
  - Clears `found`, `exhausted`, `winner_idx`, `found_key`, `search_cycles` and `fail_seen`.
  - Then moves to SEARCH.
  - `start` is ignored.
- SEARCH:
  - `cores_reset_n`=1 and `stop`=0.
  - `search_cycles` increments every cycle in SEARCH and saturates at all ones.
  - If any bit of `s_r` is set:
    - `winner_idx` is the lowest set index.
    - `found_key` is taken from `k_r` for that index.
    - `found` is set to 1 and the state moves to FOUND.
  - Otherwise, if `fail_seen | f_r` is all ones: `exhausted` is set to 1 and the state moves to EXHAUSTED.
  - Success on the same cycle as the final failure: success wins.
  - `start` is ignored.
- FOUND / EXHAUSTED:
  - `stop`=1 and `cores_reset_n`=1; the cores hold their state for inspection.
  - Result outputs are frozen.
  - Further success or failure inputs are ignored.
  - `start`=1 deasserts `stop` and moves to CLEAR (new search).
- `busy` is combinational from the state register.

## Timing
- If `core_success[i]` is high before edge E:
  - it is captured in `s_r` at E;
  - the FSM leaves SEARCH at E+1;
  - `found`, `stop`, `winner_idx` and `found_key` are valid after E+1.
  - Input-to-stop latency is therefore 2 edges.
- `found_key` comes from the same register stage as `s_r`, so the key and the success flag are always coherent.
- `search_cycles`: if SEARCH is entered at edge S and left at edge F, the final value is F−S. It is frozen afterwards.
- `start` sampled at edge T: state=CLEAR after T, SEARCH after T+2, so `cores_reset_n` rises after T+2.
- A one-cycle `core_failure` pulse is never lost, because it is held in `fail_seen`.
- Deasserting `reset_n` has no effect until the next edge; the block stays in IDLE until `start`.

## Test plan
- **Reset:** hold `reset_n`=0 with random inputs. Required: all outputs 0 and state IDLE. Release, then pulse `start` at T. Required: `busy`=1 after T and `cores_reset_n`=1 after T+2.
- **Single winner:** NUM_CORES=4, KEY_WIDTH=24. Raise `core_success[2]` with key 0x0001A3 before edge S+10. Required: `found`=1, `winner_idx`=2, `found_key`=0x0001A3, `stop`=1 after S+11, `search_cycles`=11.
- **Priority:** raise `core_success[1]` (key 0x000011) and `core_success[3]` (key 0x000033) together. Required: `winner_idx`=1 and `found_key`=0x000011.
- **Exhaustion:** one-cycle `core_failure` pulses on cores 0, 1, 2, 3 at SEARCH cycles 5, 9, 14, 20, no success. Required: `exhausted`=1, `found`=0, `stop`=1 two edges after the last pulse.
- **Tie:** core 3's final failure and `core_success[0]` on the same cycle. Required: `found`=1, `exhausted`=0, `winner_idx`=0.
- **Restart and abort:**
  - `start` during SEARCH: ignored, count continues.
  - `start` in FOUND: `stop` drops and `found`, `found_key` and `search_cycles` clear during CLEAR.
  - `reset_n` pulsed mid-SEARCH: all outputs 0 immediately and no transition until the next `start`.
